dm_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core: the target end of the M-stage load/store interface driven by the CPU datapath. It accepts one word-addressed request at a time over a valid/ready handshake, inserts a fixed number of wait states, commits byte-lane writes or returns the addressed word, and flags illegal accesses. Its `busy` output feeds the pipeline stall control, which holds the M stage and everything upstream until the response arrives.

---
 rtl/dm_responder_pkg.sv | 34 +++
 rtl/dm_responder_if.sv | 32 +++
 rtl/dm_responder_bank.sv | 39 +++
 rtl/dm_responder.sv | 120 ++++++++++++
 tb/tb_dm_responder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/dm_responder_pkg.sv
// ----------------------------------------------------------------------------
// dm_responder_pkg : state encodings and byte-enable legality for dm_responder
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dm_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_LATENCY = 2;

  localparam logic [3:0] C_BE_WORD    = 4'b1111;
  localparam logic [3:0] C_BE_HALF_LO = 4'b0011;
  localparam logic [3:0] C_BE_HALF_HI = 4'b1100;
  localparam logic [3:0] C_BE_BYTE0   = 4'b0001;
  localparam logic [3:0] C_BE_BYTE1   = 4'b0010;
  localparam logic [3:0] C_BE_BYTE2   = 4'b0100;
  localparam logic [3:0] C_BE_BYTE3   = 4'b1000;

  // Only naturally aligned byte, halfword and word lane patterns are legal.
  function automatic logic be_legal(input logic [3:0] be);
    return (be == C_BE_WORD)    || (be == C_BE_HALF_LO) || (be == C_BE_HALF_HI) ||
           (be == C_BE_BYTE0)   || (be == C_BE_BYTE1)   || (be == C_BE_BYTE2)   ||
           (be == C_BE_BYTE3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_responder_if.sv
// ----------------------------------------------------------------------------
// dm_responder_if : M-stage load/store request/response bundle
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dm_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/dm_responder_bank.sv
// ----------------------------------------------------------------------------
// dm_bank : 2^ADDR_W x 32 word store, byte-lane writes, registered read, no reset
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_bank #(
  parameter int ADDR_W = 12
) (
  input  wire logic              clk,
  input  wire logic [3:0]        we_i,
  input  wire logic              re_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [31:0]       wdata_i,
  output logic [31:0]            rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ----------------------------------------------------------------------------
// dm_responder : data-memory target with fixed wait states and access checking
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  wire logic     clk,
  input  wire logic     reset,
  dm_responder_if.slave bus
);

  localparam logic [2:0] C_LAT = 3'(LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        load_ok_q;

  logic        accept_w;
  logic        go_resp_w;
  logic        op_we_w;
  logic [31:0] op_addr_w;
  logic [3:0]  op_be_w;
  logic [31:0] op_wdata_w;
  logic        op_err_w;
  logic [31:0] bank_rdata_w;
  logic        unused_w;

  assign accept_w = (state_q == ST_IDLE) && bus.req_valid;

  // With zero wait states the access commits on the accept edge, so the live
  // request is used; otherwise the latched copy is.
  assign op_we_w    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
  assign op_addr_w  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign op_be_w    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
  assign op_wdata_w = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
  assign op_err_w   = (|op_addr_w[31:ADDR_W+2]) || !be_legal(op_be_w);

  // Gated by reset so a request held valid during reset never touches memory.
  assign go_resp_w = !reset &&
                     ((accept_w && (LATENCY == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 3'd1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          cnt_d   = C_LAT;
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_w) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
      end
      if (go_resp_w) begin
        err_q     <= op_err_w;
        load_ok_q <= !op_we_w && !op_err_w;
      end
    end
  end

  dm_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .we_i    ({4{go_resp_w && op_we_w && !op_err_w}} & op_be_w),
    .re_i    (go_resp_w && !op_we_w && !op_err_w),
    .addr_i  (op_addr_w[ADDR_W+1:2]),
    .wdata_i (op_wdata_w),
    .rdata_o (bank_rdata_w)
  );

  assign unused_w = ^{bus.req_addr[1:0], addr_q[1:0]};

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = load_ok_q ? bank_rdata_w : 32'd0;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = accept_w || (state_q == ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ----------------------------------------------------------------------------
// tb_dm_responder : directed self-checking bench, LATENCY=2 and LATENCY=0 DUTs
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dm_responder;

  logic clk = 1'b0;
  logic reset;
  int   ncomp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  dm_responder_if ifa ();
  dm_responder_if ifb ();

  dm_responder #(.ADDR_W(12), .LATENCY(2)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  dm_responder #(.ADDR_W(12), .LATENCY(0)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 DUT, checked end to end.
  task automatic req_a(input string tag, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    ifa.req_valid = 1'b1;
    ifa.req_we    = we;
    ifa.req_addr  = addr;
    ifa.req_be    = be;
    ifa.req_wdata = wd;
    #1;
    chk({tag, "/ready"}, 32'(ifa.req_ready), 32'd1);
    chk({tag, "/busy_idle"}, 32'(ifa.busy), 32'd1);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    chk({tag, "/busy_wait"}, 32'(ifa.busy), 32'd1);
    n = 1;
    while (!ifa.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'd3);
    chk({tag, "/busy_resp"}, 32'(ifa.busy), 32'd0);
    chk({tag, "/rdata"}, ifa.rsp_rdata, exp_rd);
    chk({tag, "/err"}, 32'(ifa.rsp_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "/one_shot"}, 32'(ifa.rsp_valid), 32'd0);
    chk({tag, "/rdata_hold"}, ifa.rsp_rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ifa.req_valid = 1'b1; ifa.req_we = 1'b0; ifa.req_addr = 32'd0;
    ifa.req_be = 4'hF; ifa.req_wdata = 32'd0;
    ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_addr = 32'd0;
    ifb.req_be = 4'hF; ifb.req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst/ready", 32'(ifa.req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst/rdata", ifa.rsp_rdata, 32'd0);
    chk("rst/err", 32'(ifa.rsp_err), 32'd0);
    chk("rst/busy_follows_valid", 32'(ifa.busy), 32'd1);
    chk("rst/b_rsp_valid", 32'(ifb.rsp_valid), 32'd0);
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
    #1;
    chk("rst/busy_low", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full-word store/load, then byte merge into lane 2.
    req_a("st_word", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'd0, 1'b0);
    req_a("ld_word", 1'b0, 32'h10, 4'b1111, 32'd0, 32'hDEADBEEF, 1'b0);
    req_a("st_byte2", 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 32'd0, 1'b0);
    req_a("ld_merge", 1'b0, 32'h10, 4'b1111, 32'd0, 32'hDEAABEEF, 1'b0);

    // Out-of-range address aliases word 4 if the write is not suppressed.
    req_a("st_oor", 1'b1, 32'h00010010, 4'b1111, 32'h11111111, 32'd0, 1'b1);
    req_a("ld_oor", 1'b0, 32'h00010000, 4'b1111, 32'd0, 32'd0, 1'b1);
    req_a("st_be0110", 1'b1, 32'h10, 4'b0110, 32'hFFFFFFFF, 32'd0, 1'b1);
    req_a("st_be0000", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'd0, 1'b1);
    req_a("ld_be0110", 1'b0, 32'h10, 4'b0110, 32'd0, 32'd0, 1'b1);
    req_a("ld_after_err", 1'b0, 32'h10, 4'b1111, 32'd0, 32'hDEAABEEF, 1'b0);
    req_a("st_hh", 1'b1, 32'h14, 4'b1100, 32'h5A5A0000, 32'd0, 1'b0);

    // Reset during WAIT drops the store and produces no response.
    req_a("st_old", 1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b0);
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 32'h20;
    ifa.req_be = 4'b1111; ifa.req_wdata = 32'h12345678;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    chk("abort/busy_wait", 32'(ifa.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort/ready_now", 32'(ifa.req_ready), 32'd1);
    chk("abort/no_rsp", 32'(ifa.rsp_valid), 32'd0);
    chk("abort/busy_now", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort/no_late_rsp", 32'(ifa.rsp_valid), 32'd0);
    end
    req_a("ld_old", 1'b0, 32'h20, 4'b1111, 32'd0, 32'hCAFEF00D, 1'b0);

    // LATENCY=0: request held valid yields a response every second cycle.
    @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_addr = 32'h0;
    ifb.req_be = 4'b1111; ifb.req_wdata = 32'h0BADF00D;
    #1;
    chk("b2b/busy_first", 32'(ifb.busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b/rsp_valid", 32'(ifb.rsp_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b/busy", 32'(ifb.busy), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    ifb.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b/idle", 32'(ifb.rsp_valid), 32'd0);
    ifb.req_valid = 1'b1; ifb.req_we = 1'b0;
    @(negedge clk);
    ifb.req_valid = 1'b0;
    chk("b_ld/rsp_valid", 32'(ifb.rsp_valid), 32'd1);
    chk("b_ld/rdata", ifb.rsp_rdata, 32'h0BADF00D);
    chk("b_ld/err", 32'(ifb.rsp_err), 32'd0);
    @(negedge clk);
    chk("b_ld/one_shot", 32'(ifb.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
